// File: rtl/univ_shift_reg_p.sv
// Parametrised universal shift register with a counted burst-shift engine.
// Eight step operations (hold, shifts, load, rotates, arithmetic shift, clear)
// can be applied directly every cycle, or repeated N times from one start
// command with a busy/done handshake.
module univ_shift_reg_p #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             si,
    input  logic             sil,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] q,
    output logic             q0,
    output logic             qn,
    output logic             busy,
    output logic             done
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_ZERO + 1'b1;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [2:0]       mode_r;
    logic [2:0]       mode_nxt_s;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt_s;
    logic             busy_r;
    logic             busy_nxt_s;
    logic             done_r;
    logic             done_nxt_s;
    logic             start_burst_s;
    logic             start_empty_s;

    // One register step for a given operation; d/si/sil are always live inputs.
    function automatic logic [WIDTH-1:0] step_fn(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] din,
        input logic             ser_r,
        input logic             ser_l
    );
        logic [WIDTH-1:0] res;
        case (op)
            3'b000:  res = cur;
            3'b001:  res = {ser_r, cur[WIDTH-1:1]};
            3'b010:  res = {cur[WIDTH-2:0], ser_l};
            3'b011:  res = din;
            3'b100:  res = {cur[0], cur[WIDTH-1:1]};
            3'b101:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
            3'b110:  res = {cur[WIDTH-1], cur[WIDTH-1:1]};
            3'b111:  res = {WIDTH{1'b0}};
            default: res = cur;
        endcase
        return res;
    endfunction

    assign start_burst_s = start && (count != CNT_ZERO);
    assign start_empty_s = start && (count == CNT_ZERO);

    // State register: IDLE/BURST, synchronous reset aborts any burst.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: leave IDLE on a non-empty start, leave BURST after the last step.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_burst_s) begin
                    state_nxt_s = ST_BURST;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (cnt_r == CNT_ONE) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_BURST;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output/datapath logic: next register value, counter, latched mode and handshake.
    always_comb begin
        q_nxt_s    = q_r;
        cnt_nxt_s  = cnt_r;
        mode_nxt_s = mode_r;
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_burst_s) begin
                    // The start cycle only captures the command; no step happens.
                    mode_nxt_s = mode;
                    cnt_nxt_s  = count;
                    busy_nxt_s = 1'b1;
                end else if (start_empty_s) begin
                    done_nxt_s = 1'b1;
                end else begin
                    q_nxt_s = step_fn(mode, q_r, d, si, sil);
                end
            end
            ST_BURST: begin
                q_nxt_s   = step_fn(mode_r, q_r, d, si, sil);
                cnt_nxt_s = cnt_r - 1'b1;
                if (cnt_r == CNT_ONE) begin
                    done_nxt_s = 1'b1;
                end else begin
                    busy_nxt_s = 1'b1;
                end
            end
            default: begin
                cnt_nxt_s = CNT_ZERO;
            end
        endcase
    end

    // Datapath registers: contents, step counter, latched mode, busy/done flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            q_r    <= {WIDTH{1'b0}};
            cnt_r  <= CNT_ZERO;
            mode_r <= 3'b000;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            q_r    <= q_nxt_s;
            cnt_r  <= cnt_nxt_s;
            mode_r <= mode_nxt_s;
            busy_r <= busy_nxt_s;
            done_r <= done_nxt_s;
        end
    end

    assign q    = q_r;
    assign q0   = q_r[0];
    assign qn   = q_r[WIDTH-1];
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_univ_shift_reg_p.sv
// Self-checking bench for univ_shift_reg_p: directed scenarios with literal
// expectations plus randomized traffic against a queue-based reference model.
module tb_univ_shift_reg_p;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clock;
    logic          reset;
    logic [2:0]    mode;
    logic [W-1:0]  d;
    logic          si;
    logic          sil;
    logic          start;
    logic [CW-1:0] count;
    logic [W-1:0]  q;
    logic          q0;
    logic          qn;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // reference model state: register value, pending burst operations, done flag
    logic [W-1:0] m_q;
    int           m_pend[$];
    bit           m_done;

    univ_shift_reg_p #(.WIDTH(W), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .mode(mode), .d(d), .si(si), .sil(sil),
        .start(start), .count(count), .q(q), .q0(q0), .qn(qn),
        .busy(busy), .done(done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // one step of the register from plain arithmetic on the value
    function automatic logic [W-1:0] model_op(input int op, input logic [W-1:0] v,
                                              input logic [W-1:0] dd, input bit s_r, input bit s_l);
        logic [W-1:0] top_bit;
        top_bit = 1 << (W - 1);
        case (op)
            0:       return v;
            1:       return (v >> 1) | (s_r ? top_bit : '0);
            2:       return (v << 1) | W'(s_l);
            3:       return dd;
            4:       return (v >> 1) | (v << (W - 1));
            5:       return (v << 1) | (v >> (W - 1));
            6:       return W'($signed(v) >>> 1);
            default: return '0;
        endcase
    endfunction

    // advance the model by one clock edge, using the inputs seen at that edge
    task automatic model_step();
        bit nd;
        int op;
        nd = 1'b0;
        if (reset) begin
            m_q = '0;
            m_pend.delete();
        end else if (m_pend.size() > 0) begin
            op  = m_pend.pop_front();
            m_q = model_op(op, m_q, d, si, sil);
            if (m_pend.size() == 0) nd = 1'b1;
        end else if (start) begin
            if (count == 0) nd = 1'b1;
            else for (int k = 0; k < int'(count); k++) m_pend.push_back(int'(mode));
        end else begin
            m_q = model_op(int'(mode), m_q, d, si, sil);
        end
        m_done = nd;
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
    endtask

    // compare every output to the model on each falling edge
    always @(negedge clock) begin
        if (chk_en) begin
            chk("cmp_q", 32'(q), 32'(m_q));
            chk("cmp_q0", 32'(q0), 32'(m_q[0]));
            chk("cmp_qn", 32'(qn), 32'(m_q[W-1]));
            chk("cmp_busy", 32'(busy), 32'(m_pend.size() > 0));
            chk("cmp_done", 32'(done), 32'(m_done));
        end
    end

    initial begin
        int  busy_cycles;
        bit  got_done;
        reset = 1'b1; mode = 3'd0; d = '0; si = 1'b0; sil = 1'b0;
        start = 1'b0; count = '0;
        m_q = '0; m_done = 1'b0;
        tick();
        chk_en = 1'b1;
        chk("reset_q", 32'(q), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        reset = 1'b0;

        // serial walk of a single one towards q0
        mode = 3'd3; d = 8'h80; tick();
        mode = 3'd1; si = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (i < 7) chk("walk_q0_low", 32'(q0), 32'h0);
        end
        chk("walk_q0_high", 32'(q0), 32'h1);
        chk("walk_q", 32'(q), 32'h01);

        // rotate / arithmetic shift
        mode = 3'd3; d = 8'h81; tick();
        mode = 3'd4; tick();
        chk("rotr", 32'(q), 32'hC0);
        mode = 3'd6; si = 1'b0; tick(); tick();
        chk("asr", 32'(q), 32'hF0);
        mode = 3'd5; tick();
        chk("rotl", 32'(q), 32'hE1);

        // counted burst, mode toggled while busy
        mode = 3'd3; d = 8'h01; tick();
        mode = 3'd2; sil = 1'b0; start = 1'b1; count = 4'd3; tick();
        start = 1'b0; count = 4'd0;
        chk("burst_start_q", 32'(q), 32'h01);
        busy_cycles = 0; got_done = 1'b0;
        for (int k = 0; k < 20 && !got_done; k++) begin
            if (busy) busy_cycles++;
            if (done) got_done = 1'b1;
            else begin
                mode = 3'($urandom_range(0, 7)); d = W'($urandom);
                tick();
            end
        end
        chk("burst_done_seen", 32'(got_done), 32'h1);
        chk("burst_busy_cycles", 32'(busy_cycles), 32'h3);
        chk("burst_q", 32'(q), 32'h08);

        // zero count in the done cycle, then back-to-back burst
        mode = 3'd0; start = 1'b1; count = 4'd0; tick();
        chk("zero_done", 32'(done), 32'h1);
        chk("zero_busy", 32'(busy), 32'h0);
        chk("zero_q", 32'(q), 32'h08);
        mode = 3'd5; start = 1'b1; count = 4'd2; tick();
        start = 1'b0; mode = 3'd7;
        chk("b2b_busy", 32'(busy), 32'h1);
        chk("b2b_q0", 32'(q), 32'h08);
        tick(); tick();
        chk("b2b_q", 32'(q), 32'h20);
        chk("b2b_done", 32'(done), 32'h1);
        chk("b2b_busy_end", 32'(busy), 32'h0);
        mode = 3'd0;

        // left/right serial-in
        reset = 1'b1; tick(); reset = 1'b0;
        mode = 3'd2; sil = 1'b1;
        repeat (4) tick();
        chk("sil_q", 32'(q), 32'h0F);
        chk("sil_qn", 32'(qn), 32'h0);
        mode = 3'd1; si = 1'b1;
        repeat (4) tick();
        chk("si_q", 32'(q), 32'hF0);

        // reset in the middle of a burst
        mode = 3'd3; d = 8'hA5; si = 1'b0; tick();
        mode = 3'd1; start = 1'b1; count = 4'd5; tick();
        start = 1'b0; count = 4'd0;
        tick(); tick();
        chk("midburst_q", 32'(q), 32'h29);
        reset = 1'b1; tick(); reset = 1'b0; mode = 3'd0;
        chk("abort_q", 32'(q), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("abort_no_done", 32'(done), 32'h0);
        end

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            mode  = 3'($urandom_range(0, 7));
            d     = W'($urandom);
            si    = 1'($urandom_range(0, 1));
            sil   = 1'($urandom_range(0, 1));
            start = ($urandom_range(0, 5) == 0);
            count = CW'($urandom_range(0, 15));
            tick();
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg_p.md
Name: univ_shift_reg_p

Overview:
- Parametrised universal shift register. Successor to the fixed 8-bit LUT/switch-box shift register.
- Generalised to WIDTH bits, with eight operating modes including rotate, arithmetic shift and clear.
- Adds a counted burst-shift engine with busy/done handshake, so a controller can request N shift steps with one command.
- Sits in the lab datapath as a standard register primitive; q0 stays the serial output used by existing benches.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- CNT_W, 4, width of the burst step counter; max burst = 2^CNT_W-1.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- mode  input  3  operation select (see Behaviour).
- d  input  WIDTH  parallel load data.
- si  input  1  serial in for right shift, enters q[WIDTH-1].
- sil  input  1  serial in for left shift, enters q[0].
- start  input  1  burst request; 1-cycle pulse sampled when idle.
- count  input  CNT_W  burst step count, sampled with start.
- q  output  WIDTH  register contents.
- q0  output  1  q[0]; right-shift serial out.
- qn  output  1  q[WIDTH-1]; left-shift serial out.
- busy  output  1  burst in progress.
- done  output  1  1-cycle pulse at burst completion.

Behaviour:
- One clock (clock); reset is synchronous and active-high.
- Reset: q=0, busy=0, done=0, step counter=0, latched mode=000. Reset overrides everything, including mid-burst (burst aborted, no done pulse).
- Mode encoding, one step per active edge:
  - 000 hold.
  - 001 shift right: q[i]<=q[i+1], q[WIDTH-1]<=si.
  - 010 shift left: q[i]<=q[i-1], q[0]<=sil.
  - 011 parallel load: q<=d.
  - 100 rotate right: q[WIDTH-1]<=q[0].
  - 101 rotate left: q[0]<=q[WIDTH-1].
  - 110 arithmetic shift right: MSB replicated, si ignored.
  - 111 clear: q<=0.
- Direct mode (IDLE state, start=0): mode applied every cycle; zero latency beyond the register edge.
- FSM states: IDLE, BURST.
  - IDLE & start=1 & count!=0: latch mode and count; go to BURST; busy=1 from the next cycle. The start cycle itself performs no step.
  - IDLE & start=1 & count==0: no step, stay IDLE, done=1 next cycle, busy stays 0.
  - BURST: each cycle apply the latched mode once and decrement the counter. After the step where counter reaches 0, go to IDLE. busy falls and done=1 in the cycle after the final step edge.
  - Exactly count steps are performed; busy is high for exactly count cycles.
- During BURST: mode, start and count inputs are ignored. d, si and sil are sampled live each step, so load or serial data may change per step.
- done is a single-cycle pulse, never asserted together with busy.
- start asserted in the same cycle done is high is accepted (back-to-back bursts allowed).
- Latched mode 000 in a burst still consumes count cycles with no data change. Latched mode 011 reloads d each step.
- q0 and qn are combinational from q; no extra latency.

Test Plan:
- Reset mid-burst: load 8'hA5, start mode=001 count=5, assert reset after 2 steps -> next edge q=00, busy=0, done never pulses.
- Serial walk (WIDTH=8): reset, direct mode=011 d=8'h80, then mode=001 si=0 for 7 cycles -> q0=0 for 6 cycles, q0=1 after the 7th shift, q=8'h01.
- Rotate/arith: load 8'h81; mode=100 one cycle -> q=8'hC0; mode=110 two cycles -> q=8'hF0; mode=101 one cycle -> q=8'hE1.
- Burst count: load 8'h01, start mode=010 sil=0 count=3 -> busy high exactly 3 cycles, q=8'h08, done pulses one cycle after the last step. mode toggled during busy has no effect.
- Zero count and back-to-back: start count=0 -> done next cycle, busy never 1, q unchanged. Then start count=2 mode=101 in the done cycle -> accepted, 2 rotations.
- Left/right serial-in: mode=010 sil=1 four cycles from 0 -> q=8'h0F, qn=0. Then mode=001 si=1 four cycles -> q=8'hF0.
